// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 8 data bits,
// odd parity and stop on device clock falling edges, then acknowledge check.
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       Clock_50,
  input  logic       Reset,
  input  logic [7:0] TX_data,
  input  logic       TX_start,
  output logic       TX_busy,
  output logic       TX_done,
  output logic       TX_error,
  input  logic       PS2_clock,
  input  logic       PS2_data,
  output logic       PS2_clock_drive_low,
  output logic       PS2_data_drive_low
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_INHIBIT,
    S_TX_RTS,
    S_TX_DATA,
    S_TX_PARITY,
    S_TX_STOP,
    S_TX_ACK,
    S_TX_WAIT_IDLE
  } tx_state_t;

  tx_state_t        state, state_nxt;
  logic [INH_W-1:0] inh_cnt, inh_cnt_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       tx_byte;
  logic             latch_byte;
  logic             busy_nxt, done_nxt, error_nxt, clk_low_nxt, dat_low_nxt;
  logic             ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic             ps2_dat_p0, ps2_dat_p1;
  logic             clk_fall, in_xfer;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Synchronizer stage: p0/p1 metastability flops, p2 holds previous clock for edge detect
  always_ff @(posedge Clock_50) begin
    ps2_clk_p0 <= PS2_clock;
    ps2_clk_p1 <= ps2_clk_p0;
    ps2_clk_p2 <= ps2_clk_p1;
    ps2_dat_p0 <= PS2_data;
    ps2_dat_p1 <= ps2_dat_p0;
  end

  assign clk_fall = ~ps2_clk_p1 & ps2_clk_p2;
  assign in_xfer  = (state == S_TX_DATA) || (state == S_TX_PARITY) ||
                    (state == S_TX_STOP) || (state == S_TX_ACK) ||
                    (state == S_TX_WAIT_IDLE);

  always_comb begin
    state_nxt   = state;
    inh_cnt_nxt = inh_cnt;
    to_cnt_nxt  = to_cnt;
    bit_idx_nxt = bit_idx;
    busy_nxt    = TX_busy;
    done_nxt    = 1'b0;
    error_nxt   = 1'b0;
    clk_low_nxt = PS2_clock_drive_low;
    dat_low_nxt = PS2_data_drive_low;
    latch_byte  = 1'b0;

    case (state)
      S_TX_IDLE: begin
        clk_low_nxt = 1'b0;
        dat_low_nxt = 1'b0;
        if (TX_start) begin
          latch_byte  = 1'b1;
          busy_nxt    = 1'b1;
          clk_low_nxt = 1'b1;
          inh_cnt_nxt = '0;
          state_nxt   = S_TX_INHIBIT;
        end
      end
      S_TX_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          dat_low_nxt = 1'b1;
          state_nxt   = S_TX_RTS;
        end else begin
          inh_cnt_nxt = inh_cnt + INH_W'(1);
        end
      end
      S_TX_RTS: begin
        clk_low_nxt = 1'b0;
        to_cnt_nxt  = '0;
        bit_idx_nxt = '0;
        state_nxt   = S_TX_DATA;
      end
      S_TX_DATA: begin
        if (clk_fall) begin
          dat_low_nxt = ~tx_byte[bit_idx];
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_TX_PARITY;
        end
      end
      S_TX_PARITY: begin
        if (clk_fall) begin
          dat_low_nxt = ~odd_parity(tx_byte);
          state_nxt   = S_TX_STOP;
        end
      end
      S_TX_STOP: begin
        if (clk_fall) begin
          dat_low_nxt = 1'b0;
          state_nxt   = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (clk_fall) begin
          if (!ps2_dat_p1) begin
            state_nxt = S_TX_WAIT_IDLE;
          end else begin
            error_nxt   = 1'b1;
            busy_nxt    = 1'b0;
            dat_low_nxt = 1'b0;
            state_nxt   = S_TX_IDLE;
          end
        end
      end
      S_TX_WAIT_IDLE: begin
        if (ps2_clk_p1 && ps2_dat_p1) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_TX_IDLE;
        end
      end
      default: state_nxt = S_TX_IDLE;
    endcase

    // The watchdog overrides any in-flight transition so done and error stay exclusive
    if (in_xfer) begin
      if (to_cnt == TO_LAST) begin
        clk_low_nxt = 1'b0;
        dat_low_nxt = 1'b0;
        error_nxt   = 1'b1;
        done_nxt    = 1'b0;
        busy_nxt    = 1'b0;
        state_nxt   = S_TX_IDLE;
      end else begin
        to_cnt_nxt = to_cnt + TO_W'(1);
      end
    end
  end

  // Control stage: FSM state, counters and registered pad/handshake outputs
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state               <= S_TX_IDLE;
      inh_cnt             <= '0;
      to_cnt              <= '0;
      bit_idx             <= '0;
      TX_busy             <= 1'b0;
      TX_done             <= 1'b0;
      TX_error            <= 1'b0;
      PS2_clock_drive_low <= 1'b0;
      PS2_data_drive_low  <= 1'b0;
    end else begin
      state               <= state_nxt;
      inh_cnt             <= inh_cnt_nxt;
      to_cnt              <= to_cnt_nxt;
      bit_idx             <= bit_idx_nxt;
      TX_busy             <= busy_nxt;
      TX_done             <= done_nxt;
      TX_error            <= error_nxt;
      PS2_clock_drive_low <= clk_low_nxt;
      PS2_data_drive_low  <= dat_low_nxt;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (latch_byte) tx_byte <= TX_data;
  end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends one command byte, for example 0xED (set LEDs) or 0xFF (reset), to a keyboard or mouse over the shared open-drain PS/2 clock and data lines. It generates request-to-send, shifts out data, parity and stop bits on device-generated clock edges, and checks the device acknowledge. It sits beside the PS/2 receiver on the same pins; the top level combines the drive-low enables into tri-state pads.

Parameters:
INHIBIT_CYCLES, 5000, Clock_50 cycles that clock is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum Clock_50 cycles from clock release to acknowledge (15 ms).

Ports:
Clock_50  input  1  system clock, 50 MHz
Reset  input  1  synchronous reset, active-high
TX_data  input  8  byte to send; latched when TX_start is accepted
TX_start  input  1  single-cycle request; accepted only in S_TX_IDLE
TX_busy  output  1  high from acceptance until return to S_TX_IDLE
TX_done  output  1  one-cycle pulse when acknowledge is received
TX_error  output  1  one-cycle pulse on timeout or missing acknowledge
PS2_clock  input  1  raw PS/2 clock line (asynchronous)
PS2_data  input  1  raw PS/2 data line (asynchronous)
PS2_clock_drive_low  output  1  1 = pull clock pad low, 0 = release
PS2_data_drive_low  output  1  1 = pull data pad low, 0 = release

Behaviour:
- One clock domain; every register updates on posedge Clock_50. Reset is synchronous, active-high, and takes priority over all other logic.
- Reset values: TX_busy=0, TX_done=0, TX_error=0, PS2_clock_drive_low=0, PS2_data_drive_low=0. State=S_TX_IDLE, all counters=0.
- Reset asserted mid-transfer releases both lines on the next edge and aborts with no done or error pulse.
- PS2_clock and PS2_data each pass through a 2-flop synchronizer. A falling edge is a one-cycle detect: synchronized clock = 0 and its previous value = 1.
- Odd parity: parity bit = ~^TX_data.
- Data pin drive rule: PS2_data_drive_low = ~bit. A 1 bit releases the line.
- S_TX_IDLE: both lines released. On TX_start, latch TX_data, set TX_busy=1, set PS2_clock_drive_low=1, clear the cycle counter, go to S_TX_INHIBIT.
- S_TX_INHIBIT: clock held low for INHIBIT_CYCLES cycles. On the last cycle, set PS2_data_drive_low=1 (start bit) and go to S_TX_RTS.
- S_TX_RTS: one cycle with both lines low. Then release the clock (data stays low), clear the timeout counter, bit index=0, go to S_TX_DATA.
- S_TX_DATA: on each falling edge, drive bit[index] and increment the index. After bit 7 is driven, go to S_TX_PARITY.
- S_TX_PARITY: on the next falling edge, drive the parity bit and go to S_TX_STOP.
- S_TX_STOP: on the next falling edge, release data (stop bit = 1) and go to S_TX_ACK.
- S_TX_ACK: on the next falling edge (11th), sample synchronized data.
  - 0: go to S_TX_WAIT_IDLE.
  - 1: pulse TX_error and go to S_TX_IDLE.
- S_TX_WAIT_IDLE: when synchronized clock and data are both 1, pulse TX_done and go to S_TX_IDLE. TX_busy falls in the same cycle.
- Timeout: the counter runs in S_TX_DATA through S_TX_WAIT_IDLE. On reaching TIMEOUT_CYCLES: release both lines, pulse TX_error, go to S_TX_IDLE.
- TX_done and TX_error are never asserted in the same cycle.
- TX_start while TX_busy=1 is ignored; the latched byte is unchanged.
- Bits change one synchronizer latency after the device's falling edge. This is well within the device's half-period of at least 30 us.

Test Plan:
Use INHIBIT_CYCLES=8 and TIMEOUT_CYCLES=4000. The device model runs a 40-cycle-low / 40-cycle-high clock, samples data on its rising edges and drives the acknowledge.
1. TX_data=0xED, TX_start pulse -> clock low for 8 cycles, data then low, clock released. Device samples 0, 1,0,1,1,0,1,1,1, 1, 1. Device acks -> TX_done pulses once, TX_busy falls, both drive_low outputs = 0.
2. TX_data=0x00 -> device samples 0, 0×8, parity 1, stop 1. Ack -> TX_done.
3. Device omits the acknowledge (data stays high at the 11th falling edge) -> TX_error pulses for exactly one cycle, no TX_done, lines released.
4. Device never clocks after request-to-send -> TX_error exactly 4000 cycles after clock release, lines released, TX_busy=0.
5. Second TX_start with TX_data=0xFF during case 1 -> ignored; device still receives 0xED.
6. Reset asserted after 4 data bits -> next cycle both drive_low outputs = 0, TX_busy=0, no pulses. A new 0xF4 transfer afterwards completes with TX_done.
